regfile_write_ctrl: RTL and testbench
=====================================

# regfile_write_ctrl

Write-port controller for the 32-entry integer register file (x0 hardwired zero, x1..x31 stored). Owns the file's single write port: after reset it sweeps x1..x31 to zero, then arbitrates each cycle between the in-order ALU writeback and a load-unit writeback with valid/ready handshake. It flags pending load writes for hazard logic and requests a pipeline bubble if a load write starves. Sits between the writeback stage and the register file in ID.

## Interface
Parameters:
- WIDTH, 32, data width of register file.
- CLEAR_ON_RESET, 1, 1 = run the zeroing sweep after reset; 0 = enter RUN directly.
- STARVE_LIMIT, 4, cycles a buffered load write may wait before stall_req asserts (must be ≥1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- alu_we  in  1  ALU writeback valid, no backpressure.
- alu_rd  in  5  ALU destination register.
- alu_data  in  WIDTH  ALU result.
- mem_valid  in  1  load writeback valid.
- mem_rd  in  5  load destination register.
- mem_data  in  WIDTH  load data.
- mem_ready  out  1  controller accepts load writeback this cycle.
- rf_regWrite  out  1  register file write enable.
- rf_rd_addr  out  5  register file write address.
- rf_write_data  out  WIDTH  register file write data.
- init_busy  out  1  clear sweep in progress; pipeline must hold.
- pend_valid  out  1  a load write is buffered, not yet committed.
- pend_rd  out  5  destination of buffered load write (0 when pend_valid=0).
- stall_req  out  1  request one-or-more pipeline bubbles so the buffer can drain.

## Operation
- State machine: CLEAR, RUN. 5-bit sweep counter, 1-entry load buffer (buf_valid, buf_rd, buf_data), wait counter (clog2(STARVE_LIMIT+1) bits, saturating).
- CLEAR: rf_regWrite=1, rf_rd_addr=counter, rf_write_data=0; counter 1→31, one register per cycle; after writing 31 → RUN. alu_we and mem_valid ignored; mem_ready=0; init_busy=1.
- RUN priority: (1) alu_we && alu_rd≠0 writes ALU data; (2) else buf_valid writes buffer and clears it; (3) else rf_regWrite=0.
- alu_we with alu_rd=0: no write, port treated as free for the buffer.
- mem_ready = (state==RUN) && !buf_valid. Handshake mem_valid&&mem_ready: mem_rd≠0 loads buffer; mem_rd=0 is consumed and dropped (buffer stays empty).
- WAW: if ALU writes rd equal to buf_rd in the same cycle, the buffer is squashed (cleared, never written) — ALU value is younger.
- Wait counter: cleared when buffer empty or loaded; increments each cycle buffer stays valid; stall_req = buf_valid && count ≥ STARVE_LIMIT.
- pend_valid=buf_valid, pend_rd=buf_valid ? buf_rd : 0.
- Idle output values: rf_rd_addr=0, rf_write_data=0 when rf_regWrite=0.

## Timing
- Reset (rst low, async): state=CLEAR (RUN if CLEAR_ON_RESET=0), counter=1, buffer empty, wait count 0. Outputs during reset: init_busy=1, rf_regWrite=1, rf_rd_addr=1, rf_write_data=0, mem_ready=0, pend_valid=0, pend_rd=0, stall_req=0 (CLEAR_ON_RESET=0: init_busy=0, rf_regWrite=0, mem_ready=1).
- Sweep: 31 cycles after reset release; init_busy falls on the edge that writes x31; mem_ready=1 the following cycle.
- Outputs combinational from registered state plus current alu_* inputs; ALU write lands on the same edge it is presented (0-cycle added latency).
- Load accepted at edge N → earliest commit at edge N+1; mem_ready returns high in the cycle after the commit (no same-cycle drain-and-refill).
- Reset asserted mid-sweep or with buffer full: buffered write discarded, sweep restarts at x1.

## Structure
- Shared package regfile_pkg: REG_ADDR_W=5, NUM_REGS=32, X0 address constant, state encoding ST_CLEAR/ST_RUN.
- One sub-module: regfile_wb_buffer (1-entry buffer with load, drain, squash, wait counter, stall_req). FSM and write mux stay in the top.

## Test plan
- Reset release, CLEAR_ON_RESET=1 → 31 writes of 0 to x1..x31 on consecutive cycles; init_busy low after 31 cycles; mem_ready=1 next cycle.
- RUN, mem_valid rd=5 data=0xDEADBEEF, alu_we=0 → accepted, pend_valid=1 pend_rd=5, next cycle rf_regWrite=1 addr 5 data 0xDEADBEEF, pend_valid=0.
- Buffer holds rd=7 while alu_we rd=3 every cycle, STARVE_LIMIT=4 → stall_req high after 4 waiting cycles; first cycle alu_we=0 commits rd=7 and drops stall_req.
- Buffer rd=9 and alu_we rd=9 data=0x11 same cycle → only 0x11 written to x9; buffer empty, load never written.
- mem_valid rd=0 → mem_ready=1, no buffer load, no write; alu_we rd=0 with buffer rd=4 → buffer commits that cycle.
- rst pulsed low at sweep step 12 with buffer empty, and again in RUN with buffer full → sweep restarts at x1, pend_valid=0, buffered data never written.

Source files
------------

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the integer register-file write path: register
// address width, register count, the hardwired-zero address, the sweep
// bounds and the write-controller state encoding.
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] X0      = 5'd0;
    localparam logic [REG_ADDR_W-1:0] X_FIRST = 5'd1;
    localparam logic [REG_ADDR_W-1:0] X_LAST  = REG_ADDR_W'(NUM_REGS - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // A writeback only touches the file when it is valid and not aimed at x0.
    function automatic logic is_real_write(input logic we, input logic [REG_ADDR_W-1:0] rd);
        return we && (rd != X0);
    endfunction

endpackage

// File: rtl/regfile_wb_buffer.sv
// -----------------------------------------------------------------------------
// regfile_wb_buffer
// One-entry holding buffer for a load writeback that could not use the write
// port yet. Tracks how long the entry has waited and raises stall_req once it
// has waited STARVE_LIMIT cycles.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   load              capture load_rd/load_data (only asserted when empty)
//   load_rd/load_data load destination and data
//   drain             entry is being committed to the register file
//   squash            a younger ALU write to the same register kills the entry
//   buf_valid/rd/data buffered entry (rd/data zero when empty)
//   stall_req         entry has starved for STARVE_LIMIT cycles
// -----------------------------------------------------------------------------
module regfile_wb_buffer
    import regfile_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [REG_ADDR_W-1:0] load_rd,
    input  logic [WIDTH-1:0]      load_data,
    input  logic                  drain,
    input  logic                  squash,
    output logic                  buf_valid,
    output logic [REG_ADDR_W-1:0] buf_rd,
    output logic [WIDTH-1:0]      buf_data,
    output logic                  stall_req
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic                  valid_r;
    logic [REG_ADDR_W-1:0] rd_r;
    logic [WIDTH-1:0]      data_r;
    logic [CW-1:0]         wait_cnt_r;

    // Buffer entry and saturating wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r    <= 1'b0;
            rd_r       <= X0;
            data_r     <= {WIDTH{1'b0}};
            wait_cnt_r <= {CW{1'b0}};
        end else if (load) begin
            valid_r    <= 1'b1;
            rd_r       <= load_rd;
            data_r     <= load_data;
            wait_cnt_r <= {CW{1'b0}};
        end else if (drain || squash) begin
            valid_r    <= 1'b0;
            rd_r       <= X0;
            data_r     <= {WIDTH{1'b0}};
            wait_cnt_r <= {CW{1'b0}};
        end else if (valid_r) begin
            // Entry stayed put this cycle: count the wait, holding at the limit.
            if (wait_cnt_r != LIMIT) begin
                wait_cnt_r <= wait_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end else begin
            wait_cnt_r <= {CW{1'b0}};
        end
    end

    assign buf_valid = valid_r;
    assign buf_rd    = rd_r;
    assign buf_data  = data_r;
    assign stall_req = valid_r && (wait_cnt_r >= LIMIT);

endmodule

// File: rtl/regfile_write_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_write_ctrl
// Owner of the register file's single write port. After reset it zeroes
// x1..x31 one per cycle (CLEAR), then in RUN gives the port to the ALU
// writeback first and to a buffered load writeback otherwise.
//
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   alu_we/alu_rd/alu_data         in-order ALU writeback (no backpressure)
//   mem_valid/mem_rd/mem_data      load writeback, accepted when mem_ready
//   mem_ready                      load writeback accepted this cycle
//   rf_regWrite/rf_rd_addr/
//   rf_write_data                  register file write port
//   init_busy                      zeroing sweep in progress
//   pend_valid/pend_rd             buffered load write not yet committed
//   stall_req                      buffered load has starved; insert bubbles
// -----------------------------------------------------------------------------
module regfile_write_ctrl
    import regfile_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int CLEAR_ON_RESET = 1,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_we,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [WIDTH-1:0]      alu_data,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [WIDTH-1:0]      mem_data,
    output logic                  mem_ready,
    output logic                  rf_regWrite,
    output logic [REG_ADDR_W-1:0] rf_rd_addr,
    output logic [WIDTH-1:0]      rf_write_data,
    output logic                  init_busy,
    output logic                  pend_valid,
    output logic [REG_ADDR_W-1:0] pend_rd,
    output logic                  stall_req
);

    state_t                state_r;
    logic [REG_ADDR_W-1:0] sweep_cnt_r;

    logic                  run_s;
    logic                  alu_wr_s;
    logic                  load_s;
    logic                  drain_s;
    logic                  squash_s;
    logic                  buf_valid_s;
    logic [REG_ADDR_W-1:0] buf_rd_s;
    logic [WIDTH-1:0]      buf_data_s;

    assign run_s     = (state_r == ST_RUN);
    assign alu_wr_s  = run_s && is_real_write(alu_we, alu_rd);
    assign mem_ready = run_s && !buf_valid_s;
    // A load to x0 still completes the handshake but is dropped here.
    assign load_s    = mem_valid && mem_ready && (mem_rd != X0);
    assign drain_s   = run_s && buf_valid_s && !alu_wr_s;
    // The ALU result is younger than the buffered load, so it wins the register.
    assign squash_s  = alu_wr_s && buf_valid_s && (alu_rd == buf_rd_s);

    // Sweep/run state machine and sweep address counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            sweep_cnt_r <= X_FIRST;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (sweep_cnt_r == X_LAST) begin
                        state_r <= ST_RUN;
                    end else begin
                        sweep_cnt_r <= sweep_cnt_r + 5'd1;
                    end
                end
                ST_RUN: begin
                    state_r <= ST_RUN;
                end
                default: begin
                    state_r     <= ST_CLEAR;
                    sweep_cnt_r <= X_FIRST;
                end
            endcase
        end
    end

    // Write-port mux: sweep, else ALU, else buffered load, else idle zeros.
    always_comb begin
        rf_regWrite   = 1'b0;
        rf_rd_addr    = X0;
        rf_write_data = {WIDTH{1'b0}};
        case (state_r)
            ST_CLEAR: begin
                rf_regWrite   = 1'b1;
                rf_rd_addr    = sweep_cnt_r;
                rf_write_data = {WIDTH{1'b0}};
            end
            ST_RUN: begin
                if (alu_wr_s) begin
                    rf_regWrite   = 1'b1;
                    rf_rd_addr    = alu_rd;
                    rf_write_data = alu_data;
                end else if (buf_valid_s) begin
                    rf_regWrite   = 1'b1;
                    rf_rd_addr    = buf_rd_s;
                    rf_write_data = buf_data_s;
                end else begin
                    rf_regWrite   = 1'b0;
                    rf_rd_addr    = X0;
                    rf_write_data = {WIDTH{1'b0}};
                end
            end
            default: begin
                rf_regWrite   = 1'b0;
                rf_rd_addr    = X0;
                rf_write_data = {WIDTH{1'b0}};
            end
        endcase
    end

    regfile_wb_buffer #(
        .WIDTH        (WIDTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_wb_buffer (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .load_rd   (mem_rd),
        .load_data (mem_data),
        .drain     (drain_s),
        .squash    (squash_s),
        .buf_valid (buf_valid_s),
        .buf_rd    (buf_rd_s),
        .buf_data  (buf_data_s),
        .stall_req (stall_req)
    );

    assign init_busy  = (state_r == ST_CLEAR);
    assign pend_valid = buf_valid_s;
    assign pend_rd    = buf_valid_s ? buf_rd_s : X0;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_ctrl
// Self-checking bench for regfile_write_ctrl (default parameters). Every
// expected register-file write is queued when the stimulus is applied and
// popped when the write port fires; handshake and status outputs are compared
// per cycle against a table of vectors and hand-written reset sequences.
// -----------------------------------------------------------------------------
module tb_regfile_write_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_we;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        rf_regWrite;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_write_data;
    logic        init_busy;
    logic        pend_valid;
    logic [4:0]  pend_rd;
    logic        stall_req;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t sb_q[$];

    typedef struct packed {
        logic        aw;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        ewe;
        logic [4:0]  erd;
        logic [31:0] ed;
        logic        erdy;
        logic        epv;
        logic [4:0]  eprd;
        logic        estall;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    regfile_write_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .alu_we        (alu_we),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .mem_valid     (mem_valid),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .mem_ready     (mem_ready),
        .rf_regWrite   (rf_regWrite),
        .rf_rd_addr    (rf_rd_addr),
        .rf_write_data (rf_write_data),
        .init_busy     (init_busy),
        .pend_valid    (pend_valid),
        .pend_rd       (pend_rd),
        .stall_req     (stall_req)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic aw, input logic [4:0] ard, input logic [31:0] ad,
                                input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                                input logic ewe, input logic [4:0] erd, input logic [31:0] ed,
                                input logic erdy, input logic epv, input logic [4:0] eprd,
                                input logic estall);
        vec_t v;
        v = '{aw, ard, ad, mv, mrd, md, ewe, erd, ed, erdy, epv, eprd, estall};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called just after a falling edge: drive, check, advance to next falling edge.
    task automatic cyc(input string nm,
                       input logic aw, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic ewe, input logic [4:0] erd, input logic [31:0] ed,
                       input logic erdy, input logic ebusy, input logic epv,
                       input logic [4:0] eprd, input logic estall);
        wr_t w;
        alu_we = aw; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        if (ewe) sb_q.push_back('{erd, ed});
        #1;
        chk({nm, ".we"},    {31'd0, rf_regWrite}, {31'd0, ewe});
        chk({nm, ".ready"}, {31'd0, mem_ready},   {31'd0, erdy});
        chk({nm, ".busy"},  {31'd0, init_busy},   {31'd0, ebusy});
        chk({nm, ".pv"},    {31'd0, pend_valid},  {31'd0, epv});
        chk({nm, ".prd"},   {27'd0, pend_rd},     {27'd0, eprd});
        chk({nm, ".stall"}, {31'd0, stall_req},   {31'd0, estall});
        if (rf_regWrite) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s.sb_unexpected: got write x%0d=%0h expected none", nm, rf_rd_addr, rf_write_data);
            end else begin
                w = sb_q.pop_front();
                chk({nm, ".addr"}, {27'd0, rf_rd_addr}, {27'd0, w.rd});
                chk({nm, ".data"}, rf_write_data, w.data);
            end
        end else begin
            chk({nm, ".idle_addr"}, {27'd0, rf_rd_addr}, 32'd0);
            chk({nm, ".idle_data"}, rf_write_data, 32'd0);
        end
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s.sb_missing: got no write expected %0d queued", nm, sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_sweep(input string nm, input int n, input logic junk);
        for (int k = 1; k <= n; k++) begin
            cyc($sformatf("%s_x%0d", nm, k),
                junk, 5'd2, 32'hFFFF0000, junk, 5'd6, 32'h12345678,
                1'b1, 5'(k), 32'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, ".busy"},  {31'd0, init_busy},   32'd1);
        chk({nm, ".we"},    {31'd0, rf_regWrite}, 32'd1);
        chk({nm, ".addr"},  {27'd0, rf_rd_addr},  32'd1);
        chk({nm, ".data"},  rf_write_data,        32'd0);
        chk({nm, ".ready"}, {31'd0, mem_ready},   32'd0);
        chk({nm, ".pv"},    {31'd0, pend_valid},  32'd0);
        chk({nm, ".prd"},   {27'd0, pend_rd},     32'd0);
        chk({nm, ".stall"}, {31'd0, stall_req},   32'd0);
    endtask

    task automatic idle_inputs();
        alu_we = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
    endtask

    initial begin
        // aw ard ad | mv mrd md | ewe erd ed | rdy pv prd stall
        vecs[0]  = mk(1'b0, 5'd0, 32'h0,     1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0, 1'b0);
        vecs[1]  = mk(1'b0, 5'd0, 32'h0,     1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1, 5'd5, 1'b0);
        vecs[2]  = mk(1'b0, 5'd0, 32'h0,     1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0, 1'b0);
        vecs[3]  = mk(1'b1, 5'd3, 32'h33,    1'b1, 5'd7, 32'h77,       1'b1, 5'd3, 32'h33,       1'b1, 1'b0, 5'd0, 1'b0);
        vecs[4]  = mk(1'b1, 5'd3, 32'h34,    1'b1, 5'd8, 32'h88,       1'b1, 5'd3, 32'h34,       1'b0, 1'b1, 5'd7, 1'b0);
        vecs[5]  = mk(1'b1, 5'd3, 32'h35,    1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h35,       1'b0, 1'b1, 5'd7, 1'b0);
        vecs[6]  = mk(1'b1, 5'd3, 32'h36,    1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h36,       1'b0, 1'b1, 5'd7, 1'b0);
        vecs[7]  = mk(1'b1, 5'd3, 32'h37,    1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h37,       1'b0, 1'b1, 5'd7, 1'b0);
        vecs[8]  = mk(1'b1, 5'd3, 32'h38,    1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h38,       1'b0, 1'b1, 5'd7, 1'b1);
        vecs[9]  = mk(1'b0, 5'd0, 32'h0,     1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h77,       1'b0, 1'b1, 5'd7, 1'b1);
        vecs[10] = mk(1'b0, 5'd0, 32'h0,     1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0, 1'b0);
        vecs[11] = mk(1'b0, 5'd0, 32'h0,     1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0, 1'b0);
        vecs[12] = mk(1'b1, 5'd9, 32'h11,    1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h11,       1'b0, 1'b1, 5'd9, 1'b0);
        vecs[13] = mk(1'b0, 5'd0, 32'h0,     1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0, 1'b0);
        vecs[14] = mk(1'b0, 5'd0, 32'h0,     1'b1, 5'd0, 32'hBAD,      1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0, 1'b0);
        vecs[15] = mk(1'b0, 5'd0, 32'h0,     1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0, 1'b0);
        vecs[16] = mk(1'b0, 5'd0, 32'h0,     1'b1, 5'd4, 32'h44,       1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0, 1'b0);
        vecs[17] = mk(1'b1, 5'd0, 32'hFFFF,  1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 32'h44,       1'b0, 1'b1, 5'd4, 1'b0);
        vecs[18] = mk(1'b0, 5'd0, 32'h0,     1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0, 1'b0);

        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_reset("por");
        @(negedge clk);
        rst = 1'b1;

        // Initial sweep with ALU/load traffic present that must be ignored.
        run_sweep("sweep0", 31, 1'b1);
        cyc("post_sweep0", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
            1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);

        for (int i = 0; i < NV; i++) begin
            cyc($sformatf("v%0d", i), vecs[i].aw, vecs[i].ard, vecs[i].ad,
                vecs[i].mv, vecs[i].mrd, vecs[i].md,
                vecs[i].ewe, vecs[i].erd, vecs[i].ed,
                vecs[i].erdy, 1'b0, vecs[i].epv, vecs[i].eprd, vecs[i].estall);
        end

        // Reset with the buffer full: the buffered load must never reach x20.
        cyc("fill20", 1'b1, 5'd3, 32'h5, 1'b1, 5'd20, 32'hABCD,
            1'b1, 5'd3, 32'h5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        alu_we = 1'b1; alu_rd = 5'd3; alu_data = 32'h6;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
        #1;
        chk("prerst_run.pv",  {31'd0, pend_valid}, 32'd1);
        chk("prerst_run.prd", {27'd0, pend_rd},    32'd20);
        #1;
        rst = 1'b0;
        #1;
        chk_reset("rst_run");
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        run_sweep("sweep1", 11, 1'b0);

        // Reset at sweep step 12 with the buffer empty.
        idle_inputs();
        #1;
        chk("prerst_sweep.addr", {27'd0, rf_rd_addr}, 32'd12);
        #1;
        rst = 1'b0;
        #1;
        chk_reset("rst_sweep");
        @(negedge clk);
        rst = 1'b1;
        run_sweep("sweep2", 31, 1'b0);
        cyc("post_sweep2", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
            1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        cyc("final_idle", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
            1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
